result_display: RTL and testbench
=================================

// Module: result_display
// PURPOSE
//  Downstream consumer of the ROM max-search stage. Captures the search result
//  (max value + its address) when the search reports finished.
//  Converts the selected value to decimal with a sequential shift-add-3 (double-dabble) engine.
//  Drives six static active-low 7-segment displays (HEX5 = tag letter, HEX4..HEX0 = digits).
// PARAMETERS
//  DATA_W      16  width of max_number input; conversion takes DATA_W shift cycles
//  ADDR_W      8   width of address input (zero-extended to DATA_W for conversion)
//  DIGITS      5   BCD digits produced (ceil(DATA_W*log10(2)))
//  BLANK_LZ    1   1 = blank leading zeros (digit 0 always shown)
// PORTS
//  clk         in   1       system clock, all logic on rising edge
//  rst_a_n     in   1       asynchronous, active-low reset
//  finished    in   1       search-done level from max-search stage; may stay high indefinitely
//  max_number  in   DATA_W  max value found, valid while finished=1
//  address     in   ADDR_W  address of max value, valid while finished=1
//  show_addr   in   1       0 = display max_number (tag 'H'), 1 = display address (tag 'A')
//  busy        out  1       conversion in progress
//  valid       out  1       displays hold a completed conversion of the captured result
//  hex0..hex4  out  7 each  digit segments {g,f,e,d,c,b,a}, active-low, hex0 = units
//  hex5        out  7       tag: 'H'=7'b0001001, 'A'=7'b0001000, blank=7'h7F
// BEHAVIOUR
//  Reset (async, rst_a_n=0): state IDLE; busy=0; valid=0; all hex=7'h7F; captured regs=0;
//    finished_q=0; pending=0. Takes effect immediately, also mid-conversion.
//  Trigger: finished=1 && finished_q=0 (registered edge detect). Level-high with no edge = no action.
//  States: IDLE -> CONV -> IDLE.
//   IDLE: on trigger, same edge: cap_max<=max_number, cap_addr<=address, load shift reg with
//     selected value (per show_addr), bcd<=0, cnt<=0, busy<=1, valid<=0, state<=CONV.
//     If valid=1 and show_addr differs from sel_q (selection used for last conversion),
//     or pending=1: start conversion of captured reg per show_addr, pending<=0 (no recapture).
//   CONV: each cycle: every BCD nibble >=5 gets +3, then {bcd,shift} <<= 1; cnt++.
//     After DATA_W-th shift: digit regs <= bcd, hex outputs update, sel_q<=selection,
//     valid<=1, busy<=0, state<=IDLE.
//  Latency: trigger sampled at edge 0 -> valid=1 and hex updated after edge DATA_W (16).
//  Simultaneous events:
//   - trigger during CONV: abort, recapture, restart from cnt=0 (latest result wins).
//   - show_addr change during CONV: pending<=1; reconversion starts next IDLE cycle.
//   - trigger and show_addr change same cycle: trigger path, uses new show_addr.
//  Arithmetic: address zero-extended to DATA_W; BCD nibble add is 4-bit, no carry out
//   (pre-add value <=9 so result <=12 fits). 65535 -> 6,5,5,3,5.
//  Display: hex[i] = seg(digit i); if BLANK_LZ, digits above the most significant nonzero are
//   7'h7F; value 0 shows hex0='0'=7'b1000000, hex1..hex4 blank. hex5 = tag of sel_q.
//  While busy, hex outputs hold previous values (no flicker).
// STRUCTURE
//  Package result_display_pkg: state encoding (IDLE, CONV), SEG_BLANK, SEG_TAG_H, SEG_TAG_A,
//   7-bit segment constants for digits 0-9.
//  One sub-module: seg7_dec (combinational 4-bit BCD -> 7-seg active-low, blank input);
//   instantiated DIGITS times. Conversion engine and FSM stay in result_display.
// TESTING
//  1 Reset: rst_a_n=0 -> all hex=7'h7F, busy=0, valid=0; release -> unchanged without trigger.
//  2 finished 0->1, max_number=16'hFFFF, show_addr=0 -> busy next cycle; after 16 edges valid=1,
//    hex4..0 = 6,5,5,3,5, hex5='H'; holding finished=1 causes no retrigger.
//  3 After 2, set show_addr=1 with captured address=8'hC8 -> reconversion, then hex2..0=2,0,0,
//    hex4..3 blank, hex5='A'; captured max unchanged when show_addr returns to 0.
//  4 max_number=0 trigger -> hex0='0', hex1..hex4 blank; max_number=16'd10 -> hex1='1', hex0='0'.
//  5 Trigger with max=100, then at cycle 8 drop finished and retrigger with max=42 ->
//    conversion restarts; final display 42, never 100.
//  6 Assert rst_a_n=0 mid-CONV (cycle 5) -> outputs blank immediately, busy=0; no residual
//    update after release; next trigger converts correctly.

Source files
------------

// File: rtl/result_display_pkg.sv
// Shared definitions for the result_display block.
//   state_t      : conversion FSM encoding (IDLE, CONV)
//   SEG_*        : 7-segment patterns, bit order {g,f,e,d,c,b,a}, active-low
//   seg_of()     : BCD digit -> segment pattern (non-decimal codes show blank)
package result_display_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    CONV = 1'b1
  } state_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_TAG_H = 7'b0001001;
  localparam logic [6:0] SEG_TAG_A = 7'b0001000;

  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0010000;

  function automatic logic [6:0] seg_of(input logic [3:0] digit);
    logic [6:0] seg;
    case (digit)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/result_display_seg7_dec.sv
// seg7_dec: combinational BCD digit to active-low 7-segment decoder.
//   bcd   in  4  decimal digit 0-9
//   blank in  1  force all segments off
//   seg   out 7  {g,f,e,d,c,b,a}, active-low
module seg7_dec
  import result_display_pkg::*;
(
  input  logic [3:0] bcd,
  input  logic       blank,
  output logic [6:0] seg
);

  always_comb begin
    seg = blank ? SEG_BLANK : seg_of(bcd);
  end

endmodule

// File: rtl/result_display.sv
// result_display: captures the max-search result on the rising edge of
// 'finished', converts the selected value (max or its address) to decimal
// with a sequential double-dabble engine, and drives six 7-segment displays.
//   clk, rst_a_n          clock / asynchronous active-low reset
//   finished              search-done level; only its rising edge triggers
//   max_number, address   result to capture
//   show_addr             0 = show max (tag 'H'), 1 = show address (tag 'A')
//   busy, valid           conversion running / displays hold a finished result
//   hex0..hex4            digit segments (hex0 = units); hex5 = tag
module result_display
  import result_display_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 8,
  parameter int DIGITS   = 5,
  parameter int BLANK_LZ = 1
) (
  input  logic              clk,
  input  logic              rst_a_n,
  input  logic              finished,
  input  logic [DATA_W-1:0] max_number,
  input  logic [ADDR_W-1:0] address,
  input  logic              show_addr,
  output logic              busy,
  output logic              valid,
  output logic [6:0]        hex0,
  output logic [6:0]        hex1,
  output logic [6:0]        hex2,
  output logic [6:0]        hex3,
  output logic [6:0]        hex4,
  output logic [6:0]        hex5
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  state_t                  state_reg, state_next;
  logic                    finished_q;
  logic [DATA_W-1:0]       cap_max_reg, cap_max_next;
  logic [ADDR_W-1:0]       cap_addr_reg, cap_addr_next;
  logic [DATA_W-1:0]       shift_reg, shift_next;
  logic [BCD_W-1:0]        bcd_reg, bcd_next;
  logic [CNT_W-1:0]        cnt_reg, cnt_next;
  logic                    busy_reg, busy_next;
  logic                    valid_reg, valid_next;
  logic                    pending_reg, pending_next;
  logic                    sel_q, sel_q_next;           // selection shown on the displays
  logic                    conv_sel_reg, conv_sel_next; // selection of the running conversion
  logic [DIGITS-1:0][6:0]  hex_reg, hex_next;
  logic [6:0]              tag_reg, tag_next;

  logic                    trigger;
  logic [BCD_W-1:0]        bcd_adj;
  logic [BCD_W+DATA_W-1:0] dd_shifted;
  logic [BCD_W-1:0]        bcd_shifted;
  logic [DATA_W-1:0]       shift_shifted;
  logic [DATA_W-1:0]       addr_in_ext, addr_cap_ext;
  logic [DIGITS-1:0]       blank_lz;
  logic [DIGITS-1:0][6:0]  dec_seg;

  assign trigger      = finished & ~finished_q;
  assign addr_in_ext  = {{(DATA_W-ADDR_W){1'b0}}, address};
  assign addr_cap_ext = {{(DATA_W-ADDR_W){1'b0}}, cap_addr_reg};

  // Double-dabble step: nibbles >= 5 get +3 (4-bit, cannot overflow since
  // a nibble never exceeds 9), then the whole {bcd,shift} pair moves left.
  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_adj
      assign bcd_adj[4*gi +: 4] = (bcd_reg[4*gi +: 4] >= 4'd5) ?
                                  bcd_reg[4*gi +: 4] + 4'd3 : bcd_reg[4*gi +: 4];
    end
  endgenerate

  assign dd_shifted    = {bcd_adj, shift_reg} << 1;
  assign bcd_shifted   = dd_shifted[BCD_W+DATA_W-1:DATA_W];
  assign shift_shifted = dd_shifted[DATA_W-1:0];

  // Decoders look at the value being committed on the final shift so the
  // display registers load the finished digits on the same edge as valid.
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_dec
      if (gi == 0) begin : g_units
        assign blank_lz[gi] = 1'b0;
      end else begin : g_upper
        assign blank_lz[gi] = (BLANK_LZ != 0) && ~(|bcd_shifted[BCD_W-1:4*gi]);
      end
      seg7_dec u_dec (
        .bcd   (bcd_shifted[4*gi +: 4]),
        .blank (blank_lz[gi]),
        .seg   (dec_seg[gi])
      );
    end
  endgenerate

  always_comb begin
    state_next    = state_reg;
    cap_max_next  = cap_max_reg;
    cap_addr_next = cap_addr_reg;
    shift_next    = shift_reg;
    bcd_next      = bcd_reg;
    cnt_next      = cnt_reg;
    busy_next     = busy_reg;
    valid_next    = valid_reg;
    pending_next  = pending_reg;
    sel_q_next    = sel_q;
    conv_sel_next = conv_sel_reg;
    hex_next      = hex_reg;
    tag_next      = tag_reg;

    if (trigger) begin
      // New result always wins, including over a conversion in flight.
      cap_max_next  = max_number;
      cap_addr_next = address;
      shift_next    = show_addr ? addr_in_ext : max_number;
      bcd_next      = '0;
      cnt_next      = '0;
      busy_next     = 1'b1;
      valid_next    = 1'b0;
      pending_next  = 1'b0;
      conv_sel_next = show_addr;
      state_next    = CONV;
    end else begin
      case (state_reg)
        IDLE: begin
          if (pending_reg || (valid_reg && (show_addr != sel_q))) begin
            shift_next    = show_addr ? addr_cap_ext : cap_max_reg;
            bcd_next      = '0;
            cnt_next      = '0;
            busy_next     = 1'b1;
            valid_next    = 1'b0;
            pending_next  = 1'b0;
            conv_sel_next = show_addr;
            state_next    = CONV;
          end
        end
        CONV: begin
          shift_next = shift_shifted;
          bcd_next   = bcd_shifted;
          cnt_next   = cnt_reg + 1'b1;
          if (show_addr != conv_sel_reg) begin
            pending_next = 1'b1;
          end
          if (cnt_reg == CNT_LAST) begin
            hex_next   = dec_seg;
            tag_next   = conv_sel_reg ? SEG_TAG_A : SEG_TAG_H;
            sel_q_next = conv_sel_reg;
            valid_next = 1'b1;
            busy_next  = 1'b0;
            state_next = IDLE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_a_n) begin
    if (!rst_a_n) begin
      state_reg    <= IDLE;
      finished_q   <= 1'b0;
      cap_max_reg  <= '0;
      cap_addr_reg <= '0;
      shift_reg    <= '0;
      bcd_reg      <= '0;
      cnt_reg      <= '0;
      busy_reg     <= 1'b0;
      valid_reg    <= 1'b0;
      pending_reg  <= 1'b0;
      sel_q        <= 1'b0;
      conv_sel_reg <= 1'b0;
      hex_reg      <= {DIGITS{SEG_BLANK}};
      tag_reg      <= SEG_BLANK;
    end else begin
      state_reg    <= state_next;
      finished_q   <= finished;
      cap_max_reg  <= cap_max_next;
      cap_addr_reg <= cap_addr_next;
      shift_reg    <= shift_next;
      bcd_reg      <= bcd_next;
      cnt_reg      <= cnt_next;
      busy_reg     <= busy_next;
      valid_reg    <= valid_next;
      pending_reg  <= pending_next;
      sel_q        <= sel_q_next;
      conv_sel_reg <= conv_sel_next;
      hex_reg      <= hex_next;
      tag_reg      <= tag_next;
    end
  end

  assign busy  = busy_reg;
  assign valid = valid_reg;
  assign hex0  = hex_reg[0];
  assign hex1  = hex_reg[1];
  assign hex2  = hex_reg[2];
  assign hex3  = hex_reg[3];
  assign hex4  = hex_reg[4];
  assign hex5  = tag_reg;

endmodule

// File: tb/tb_result_display.sv
// Testbench for result_display: scoreboard of expected display images,
// pushed when a conversion is requested and popped when valid rises.
module tb_result_display;

  logic        clk = 1'b0;
  logic        rst_a_n = 1'b1;
  logic        finished = 1'b0;
  logic [15:0] max_number = '0;
  logic [7:0]  address = '0;
  logic        show_addr = 1'b0;
  logic        busy, valid;
  logic [6:0]  hex0, hex1, hex2, hex3, hex4, hex5;

  int n_vec = 0;
  int n_err = 0;
  logic [41:0] sb[$];
  logic [41:0] all_blank = {42{1'b1}};

  result_display dut (
    .clk(clk), .rst_a_n(rst_a_n), .finished(finished),
    .max_number(max_number), .address(address), .show_addr(show_addr),
    .busy(busy), .valid(valid),
    .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3), .hex4(hex4), .hex5(hex5)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic logic [6:0] seg_model(int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'h7F;
    endcase
  endfunction

  // {hex5, hex4, ..., hex0} for decimal value v with leading zeros blanked.
  function automatic logic [41:0] expect_disp(int v, bit sel);
    logic [41:0] r;
    int p = 1;
    r[41:35] = sel ? 7'b0001000 : 7'b0001001;
    for (int i = 0; i < 5; i++) begin
      if (i > 0 && v < p) r[i*7 +: 7] = 7'h7F;
      else                r[i*7 +: 7] = seg_model((v / p) % 10);
      p = p * 10;
    end
    return r;
  endfunction

  function automatic logic [41:0] observed();
    return {hex5, hex4, hex3, hex2, hex1, hex0};
  endfunction

  task automatic start(int v, logic [7:0] a, bit sel);
    @(negedge clk);
    finished = 1'b0;
    @(negedge clk);
    max_number = 16'(v);
    address    = a;
    show_addr  = sel;
    finished   = 1'b1;
    sb.push_back(expect_disp(sel ? int'(a) : v, sel));
    $display("drive: trigger value=%0d addr=%0d show_addr=%0d", v, a, sel);
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (n < 64) begin
      @(negedge clk);
      n++;
      if (valid === 1'b1) break;
    end
  endtask

  task automatic pop_expected(output logic [41:0] e);
    if (sb.size() == 0) e = 'x;
    else e = sb.pop_front();
  endtask

  task automatic test_reset();
    #2 rst_a_n = 1'b0;
    @(negedge clk);
    n_vec++;
    if (observed() !== all_blank || busy !== 1'b0 || valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_state: got hex=%h busy=%b valid=%b want hex=%h busy=0 valid=0", observed(), busy, valid, all_blank);
    end
    rst_a_n = 1'b1;
    repeat (5) @(negedge clk);
    n_vec++;
    if (observed() !== all_blank || busy !== 1'b0 || valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_release: got hex=%h busy=%b valid=%b want idle blank", observed(), busy, valid);
    end
    $display("reset: hex=%h busy=%b valid=%b", observed(), busy, valid);
  endtask

  task automatic test_max_ffff();
    int n;
    logic [41:0] e;
    start(65535, 8'hC8, 1'b0);
    @(negedge clk);
    n_vec++;
    if (busy !== 1'b1 || valid !== 1'b0) begin
      n_err++;
      $display("FAIL ffff_busy: got busy=%b valid=%b want busy=1 valid=0", busy, valid);
    end
    wait_valid(n);
    n_vec++;
    if (n != 16) begin
      n_err++;
      $display("FAIL ffff_latency: got %0d edges want 16", n);
    end
    pop_expected(e);
    n_vec++;
    if (observed() !== e || busy !== 1'b0) begin
      n_err++;
      $display("FAIL ffff_display: got %h busy=%b want %h busy=0", observed(), busy, e);
    end
    $display("result: hex=%h valid=%b edges=%0d", observed(), valid, n);
    max_number = 16'h1234;  // finished stays high: must not be recaptured
    repeat (6) @(negedge clk);
    n_vec++;
    if (busy !== 1'b0 || valid !== 1'b1) begin
      n_err++;
      $display("FAIL ffff_no_retrigger: got busy=%b valid=%b want busy=0 valid=1", busy, valid);
    end
  endtask

  task automatic test_show_addr();
    int n;
    logic [41:0] e;
    show_addr = 1'b1;
    sb.push_back(expect_disp(200, 1'b1));
    @(negedge clk);
    n_vec++;
    if (busy !== 1'b1) begin
      n_err++;
      $display("FAIL addr_reconv_busy: got busy=%b want 1", busy);
    end
    wait_valid(n);
    pop_expected(e);
    n_vec++;
    if (n >= 64 || observed() !== e) begin
      n_err++;
      $display("FAIL addr_display: got %h (edges %0d) want %h", observed(), n, e);
    end
    $display("result: hex=%h show_addr=1 edges=%0d", observed(), n);
    show_addr = 1'b0;
    sb.push_back(expect_disp(65535, 1'b0));
    wait_valid(n);
    pop_expected(e);
    n_vec++;
    if (n >= 64 || observed() !== e) begin
      n_err++;
      $display("FAIL addr_back_to_max: got %h (edges %0d) want %h", observed(), n, e);
    end
    $display("result: hex=%h show_addr=0 edges=%0d", observed(), n);
  endtask

  task automatic test_zero_ten();
    int n;
    logic [41:0] e;
    start(0, 8'd0, 1'b0);
    wait_valid(n);
    pop_expected(e);
    n_vec++;
    if (n >= 64 || observed() !== e) begin
      n_err++;
      $display("FAIL zero_display: got %h (edges %0d) want %h", observed(), n, e);
    end
    $display("result: value=0 hex=%h", observed());
    start(10, 8'd0, 1'b0);
    wait_valid(n);
    pop_expected(e);
    n_vec++;
    if (n >= 64 || observed() !== e) begin
      n_err++;
      $display("FAIL ten_display: got %h (edges %0d) want %h", observed(), n, e);
    end
    $display("result: value=10 hex=%h", observed());
  endtask

  task automatic test_restart();
    int n;
    logic [41:0] e;
    start(100, 8'd0, 1'b0);
    repeat (8) @(negedge clk);
    finished = 1'b0;
    @(negedge clk);
    max_number = 16'd42;
    finished   = 1'b1;
    void'(sb.pop_back());  // the aborted conversion never reaches the display
    sb.push_back(expect_disp(42, 1'b0));
    $display("drive: retrigger value=42 during conversion");
    wait_valid(n);
    n_vec++;
    if (n != 17) begin
      n_err++;
      $display("FAIL restart_latency: got %0d edges want 17", n);
    end
    pop_expected(e);
    n_vec++;
    if (observed() !== e) begin
      n_err++;
      $display("FAIL restart_display: got %h want %h", observed(), e);
    end
    $display("result: value=42 hex=%h edges=%0d", observed(), n);
  endtask

  task automatic test_reset_mid();
    int n;
    logic [41:0] e;
    start(12345, 8'd0, 1'b0);
    repeat (5) @(negedge clk);
    rst_a_n  = 1'b0;
    finished = 1'b0;
    #1;
    n_vec++;
    if (observed() !== all_blank || busy !== 1'b0 || valid !== 1'b0) begin
      n_err++;
      $display("FAIL midreset_immediate: got hex=%h busy=%b valid=%b want blank idle", observed(), busy, valid);
    end
    sb.delete();
    repeat (2) @(negedge clk);
    rst_a_n = 1'b1;
    repeat (24) @(negedge clk);
    n_vec++;
    if (observed() !== all_blank || busy !== 1'b0 || valid !== 1'b0) begin
      n_err++;
      $display("FAIL midreset_residual: got hex=%h busy=%b valid=%b want blank idle", observed(), busy, valid);
    end
    $display("reset mid-conversion: hex=%h busy=%b valid=%b", observed(), busy, valid);
    start(12345, 8'd7, 1'b0);
    wait_valid(n);
    pop_expected(e);
    n_vec++;
    if (n != 17 || observed() !== e) begin
      n_err++;
      $display("FAIL midreset_recover: got %h (edges %0d) want %h (edges 17)", observed(), n, e);
    end
    $display("result: value=12345 hex=%h", observed());
    start(500, 8'd255, 1'b1);
    wait_valid(n);
    pop_expected(e);
    n_vec++;
    if (n >= 64 || observed() !== e) begin
      n_err++;
      $display("FAIL addr_trigger: got %h (edges %0d) want %h", observed(), n, e);
    end
    $display("result: addr=255 hex=%h", observed());
  endtask

  initial begin
    test_reset();
    test_max_ffff();
    test_show_addr();
    test_zero_ten();
    test_restart();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
